// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_pkg
// Description : Shared module-select codes, opcodes, instruction layout and
//               fetch FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_pkg;

    localparam logic [3:0] MainMemEn    = 4'd0;
    localparam logic [3:0] InstrMemEn   = 4'd1;
    localparam logic [3:0] MatrixAluEn  = 4'd2;
    localparam logic [3:0] IntegerAluEn = 4'd3;
    localparam logic [3:0] ExecuteEn    = 4'd4;

    localparam logic [7:0] MMult     = 8'h00;
    localparam logic [7:0] MAdd      = 8'h01;
    localparam logic [7:0] MSub      = 8'h02;
    localparam logic [7:0] MTranspose = 8'h03;
    localparam logic [7:0] MScale    = 8'h04;
    localparam logic [7:0] MScaleImm = 8'h05;
    localparam logic [7:0] IntAdd    = 8'h10;
    localparam logic [7:0] IntSub    = 8'h11;
    localparam logic [7:0] IntMult   = 8'h12;
    localparam logic [7:0] IntDiv    = 8'h13;
    localparam logic [7:0] Stop      = 8'hFF;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] dest;
        logic [7:0] src1;
        logic [7:0] src2;
    } instr_t;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_REQ   = 3'd1,
        FS_WAIT  = 3'd2,
        FS_ISSUE = 3'd3,
        FS_HALT  = 3'd4
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : instr_line_buffer
// Description : Holds one ROM line and presents the word selected by slot.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_line_buffer
    import instr_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 8,
    parameter int SLOT_W     = $clog2(LINE_WORDS)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         load_i,
    input  logic [WORD_W*LINE_WORDS-1:0] line_i,
    input  logic [SLOT_W-1:0]            slot_i,
    output instr_t                       instr_o
);

    logic [WORD_W*LINE_WORDS-1:0] line_q;
    logic [WORD_W-1:0]            w_words [LINE_WORDS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= '0;
        end else if (load_i) begin
            line_q <= line_i;
        end
    end

    // Word 0 lives in the most significant bits of the line.
    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_words
        assign w_words[k] = line_q[WORD_W*(LINE_WORDS-1-k) +: WORD_W];
    end

    assign instr_o = instr_t'(w_words[slot_i]);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetches instruction lines from ROM and issues one decoded
//               instruction per handshake until a Stop is handed off.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import instr_pkg::*;
#(
    parameter int         WORD_W     = 32,
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] MEM_SEL    = 4'd1,
    parameter logic [11:0] START_LINE = 12'h000,
    parameter logic [7:0] STOP_OP    = 8'hFF
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Start,
    output logic [15:0]                  address,
    output logic                         nRead,
    input  logic [WORD_W*LINE_WORDS-1:0] InstructDataIn,
    output logic [WORD_W-1:0]            InstrOut,
    output logic [7:0]                   Opcode,
    output logic [7:0]                   Dest,
    output logic [7:0]                   Src1,
    output logic [7:0]                   Src2,
    output logic                         InstrValid,
    input  logic                         InstrReady,
    output logic                         Halted,
    output logic                         Busy
);

    localparam int                SLOT_W    = $clog2(LINE_WORDS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LINE_WORDS - 1);

    fetch_state_t      state_q, state_d;
    logic [11:0]       line_q, line_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [15:0]       addr_q;
    logic [15:0]       w_address;
    logic              w_load;
    logic              w_valid;
    logic              w_advance;
    instr_t            w_cur;

    instr_line_buffer #(
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS),
        .SLOT_W     (SLOT_W)
    ) u_line_buffer (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .load_i  (w_load),
        .line_i  (InstructDataIn),
        .slot_i  (slot_q),
        .instr_o (w_cur)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= FS_IDLE;
            line_q  <= '0;
            slot_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            slot_q  <= slot_d;
            addr_q  <= w_address;
        end
    end

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        slot_d    = slot_q;
        w_load    = 1'b0;
        w_valid   = 1'b0;
        w_advance = 1'b0;
        case (state_q)
            FS_IDLE, FS_HALT: begin
                if (Start) begin
                    line_d  = START_LINE;
                    slot_d  = '0;
                    state_d = FS_REQ;
                end
            end
            FS_REQ: begin
                state_d = FS_WAIT;
            end
            FS_WAIT: begin
                w_load  = 1'b1;
                slot_d  = '0;
                state_d = FS_ISSUE;
            end
            FS_ISSUE: begin
                // An all-zero word marks an empty slot and is skipped silently.
                if (w_cur == '0) begin
                    w_advance = 1'b1;
                end else begin
                    w_valid = 1'b1;
                    if (InstrReady) begin
                        if (w_cur.opcode == STOP_OP) begin
                            state_d = FS_HALT;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
        if (w_advance) begin
            if (slot_q == LAST_SLOT) begin
                line_d  = line_q + 12'd1;
                slot_d  = '0;
                state_d = FS_REQ;
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end
    end

    assign w_address  = (state_q == FS_REQ) ? {MEM_SEL, line_q} : addr_q;
    assign address    = w_address;
    assign nRead      = (state_q != FS_REQ);
    assign InstrOut   = w_cur;
    assign Opcode     = w_cur.opcode;
    assign Dest       = w_cur.dest;
    assign Src1       = w_cur.src1;
    assign Src2       = w_cur.src2;
    assign InstrValid = w_valid;
    assign Halted     = (state_q == FS_HALT);
    assign Busy       = (state_q == FS_REQ) || (state_q == FS_WAIT) || (state_q == FS_ISSUE);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [15:0]  address;
    logic         nRead;
    logic [255:0] InstructDataIn;
    logic [31:0]  InstrOut;
    logic [7:0]   Opcode, Dest, Src1, Src2;
    logic         InstrValid;
    logic         InstrReady;
    logic         Halted;
    logic         Busy;

    logic         Start2;
    logic [15:0]  address2;
    logic         nRead2;
    logic [255:0] InstructDataIn2;
    logic [31:0]  InstrOut2;
    logic [7:0]   Opcode2, Dest2, Src12, Src22;
    logic         InstrValid2;
    logic         InstrReady2;
    logic         Halted2;
    logic         Busy2;

    logic [255:0] rom [16];
    logic [31:0]  exp0 [8];
    logic [255:0] line0, line1, line_empty;

    int n_checks;
    int n_errors;

    instr_fetch_unit u_dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .address(address), .nRead(nRead),
        .InstructDataIn(InstructDataIn), .InstrOut(InstrOut), .Opcode(Opcode),
        .Dest(Dest), .Src1(Src1), .Src2(Src2), .InstrValid(InstrValid),
        .InstrReady(InstrReady), .Halted(Halted), .Busy(Busy)
    );

    instr_fetch_unit #(.START_LINE(12'hFFF)) u_dut_wrap (
        .Clk(Clk), .Reset(Reset), .Start(Start2), .address(address2), .nRead(nRead2),
        .InstructDataIn(InstructDataIn2), .InstrOut(InstrOut2), .Opcode(Opcode2),
        .Dest(Dest2), .Src1(Src12), .Src2(Src22), .InstrValid(InstrValid2),
        .InstrReady(InstrReady2), .Halted(Halted2), .Busy(Busy2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ROM model: samples the strobe on the closing edge of the request cycle.
    always @(posedge Clk) begin
        if (!nRead)  InstructDataIn  <= rom[address[3:0]];
        if (!nRead2) InstructDataIn2 <= rom[address2[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    initial begin
        int lows;
        int first_i;
        int hs;
        logic [31:0] first_word;

        n_checks = 0;
        n_errors = 0;
        exp0[0] = 32'h01020001; exp0[1] = 32'h10100908;
        exp0[2] = 32'h02030200; exp0[3] = 32'h03040200;
        exp0[4] = 32'h04050310; exp0[5] = 32'h00060403;
        exp0[6] = 32'h120a0100; exp0[7] = 32'h11110a01;
        line0      = {exp0[0], exp0[1], exp0[2], exp0[3], exp0[4], exp0[5], exp0[6], exp0[7]};
        line1      = {32'hFF000000, {7{32'h01010101}}};
        line_empty = {{6{32'h00000000}}, 32'h130b0a11, 32'hFF000000};
        for (int i = 0; i < 16; i++) rom[i] = '0;
        rom[0]  = line0;
        rom[1]  = line1;
        rom[15] = line0;
        InstructDataIn  = '0;
        InstructDataIn2 = '0;

        Reset = 1'b1; Start = 1'b0; Start2 = 1'b0;
        InstrReady = 1'b1; InstrReady2 = 1'b1;
        repeat (3) tick();
        chk("rst_valid",  32'(InstrValid), 32'd0);
        chk("rst_nread",  32'(nRead),      32'd1);
        chk("rst_addr",   32'(address),    32'h0);
        chk("rst_halted", 32'(Halted),     32'd0);
        chk("rst_busy",   32'(Busy),       32'd0);
        Reset = 1'b0;
        tick();

        // Test 1: first line, consecutive issue, next line request
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("t1_req_nread", 32'(nRead),   32'd0);
        chk("t1_req_addr",  32'(address), 32'h1000);
        chk("t1_req_busy",  32'(Busy),    32'd1);
        chk("t1_req_valid", 32'(InstrValid), 32'd0);
        tick();
        chk("t1_wait_nread", 32'(nRead),      32'd1);
        chk("t1_wait_addr",  32'(address),    32'h1000);
        chk("t1_wait_valid", 32'(InstrValid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("t1_valid%0d", k), 32'(InstrValid), 32'd1);
            chk($sformatf("t1_word%0d", k),  InstrOut,        exp0[k]);
        end
        tick();
        chk("t1_req2_nread", 32'(nRead),   32'd0);
        chk("t1_req2_addr",  32'(address), 32'h1001);

        // Test 3: Stop at line 1 slot 0
        tick();
        tick();
        chk("t3_stop_word",  InstrOut,        32'hFF000000);
        chk("t3_stop_op",    32'(Opcode),     32'hFF);
        chk("t3_stop_valid", 32'(InstrValid), 32'd1);
        tick();
        chk("t3_halted", 32'(Halted),     32'd1);
        chk("t3_valid",  32'(InstrValid), 32'd0);
        chk("t3_busy",   32'(Busy),       32'd0);
        lows = 0;
        repeat (10) begin
            tick();
            if (!nRead) lows++;
        end
        chk("t3_no_reads", 32'(lows), 32'd0);

        // Test 2: backpressure on slot 2
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("t2_halt_clr", 32'(Halted), 32'd0);
        tick();
        tick();
        tick();
        tick();
        chk("t2_slot2", InstrOut, 32'h02030200);
        InstrReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("t2_hold_word%0d", c),  InstrOut,        32'h02030200);
            chk($sformatf("t2_hold_valid%0d", c), 32'(InstrValid), 32'd1);
        end
        chk("t2_opcode", 32'(Opcode), 32'h02);
        chk("t2_dest",   32'(Dest),   32'h03);
        chk("t2_src1",   32'(Src1),   32'h02);
        chk("t2_src2",   32'(Src2),   32'h00);
        InstrReady = 1'b1;
        tick();
        chk("t2_slot3", InstrOut, 32'h03040200);
        repeat (8) tick();
        chk("t2_halted", 32'(Halted), 32'd1);

        // Test 4: empty slots skipped
        rom[0] = line_empty;
        Start = 1'b1;
        first_i = -1;
        first_word = '0;
        hs = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) Start = 1'b0;
            if (InstrValid && first_i < 0) begin
                first_i = i;
                first_word = InstrOut;
            end
            if (InstrValid && InstrReady) hs++;
        end
        chk("t4_first_cycle", 32'(first_i), 32'd9);
        chk("t4_first_word",  first_word,   32'h130b0a11);
        chk("t4_handshakes",  32'(hs),      32'd2);
        chk("t4_halted",      32'(Halted),  32'd1);

        // Test 5: reset during a pending issue
        rom[0] = line0;
        InstrReady = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        chk("t5_pending_valid", 32'(InstrValid), 32'd1);
        chk("t5_pending_word",  InstrOut,        32'h01020001);
        Reset = 1'b1;
        tick();
        chk("t5_valid",  32'(InstrValid), 32'd0);
        chk("t5_nread",  32'(nRead),      32'd1);
        chk("t5_addr",   32'(address),    32'h0);
        chk("t5_halted", 32'(Halted),     32'd0);
        chk("t5_busy",   32'(Busy),       32'd0);
        Reset = 1'b0;
        InstrReady = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("t5_restart_nread", 32'(nRead),   32'd0);
        chk("t5_restart_addr",  32'(address), 32'h1000);

        // Test 6: line index wrap and Start ignored while busy
        Start2 = 1'b1;
        tick();
        Start2 = 1'b0;
        chk("t6_req_addr",  32'(address2), 32'h1FFF);
        chk("t6_req_nread", 32'(nRead2),   32'd0);
        tick();
        Start2 = 1'b1;
        tick();
        Start2 = 1'b0;
        chk("t6_word0", InstrOut2, exp0[0]);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("t6_word%0d", k), InstrOut2, exp0[k]);
            Start2 = (k == 3);
        end
        Start2 = 1'b0;
        tick();
        chk("t6_wrap_addr",  32'(address2), 32'h1000);
        chk("t6_wrap_nread", 32'(nRead2),   32'd0);
        chk("t6_wrap_busy",  32'(Busy2),    32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
